ats21_cmd_sequencer: RTL and testbench

- Host-side front end for the ATS21 timer block; shares the ATS21 two-client control port between two command sources, A and B.
- Each source hands over a complete 32-bit instruction through a valid/ready handshake.
- The block arbitrates conflicting commands and runs the ATS21 transaction: req pulse, wait for ready, high beat, low beat, fixed wait, status sample.
- It returns a per-client ack/nack/error response and sits between the host register interface and ATS21.

---
 rtl/ats21_pkg.sv | 46 ++++
 rtl/ats21_cmd_sequencer_if.sv | 34 +++
 rtl/ats21_cmd_conflict.sv | 53 +++++
 rtl/ats21_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ats21_cmd_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ats21_pkg.sv
// ATS21 shared types: opcodes, instruction word, sequencer states.
// Opcode class helpers are used by the conflict check.
package ats21_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  target;
    logic [23:0] payload;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RDY,
    S_BEAT_HI,
    S_BEAT_LO,
    S_WAIT_STAT,
    S_RESP
  } state_e;

  function automatic logic is_clock_op(
    input op_e op
  );
    return (op == OP_SET_CLK) ||
           (op == OP_EN_CLK);
  endfunction

  function automatic logic is_alarm_op(
    input op_e op
  );
    return (op == OP_SET_ALM) ||
           (op == OP_SET_TMR) ||
           (op == OP_EN_ALM);
  endfunction

endpackage

// File: rtl/ats21_cmd_sequencer_if.sv
// Host-side command handshake and response bundle
// for the ATS21 command sequencer.
interface ats21_cmd_sequencer_if;
  logic        a_valid;
  logic [31:0] a_cmd;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_cmd;
  logic        b_ready;
  logic        rsp_valid;
  logic        rsp_a_used;
  logic        rsp_a_ack;
  logic        rsp_b_used;
  logic        rsp_b_ack;
  logic        rsp_err;

  modport master (
    output a_valid, a_cmd,
    output b_valid, b_cmd,
    input  a_ready, b_ready,
    input  rsp_valid, rsp_err,
    input  rsp_a_used, rsp_a_ack,
    input  rsp_b_used, rsp_b_ack
  );

  modport slave (
    input  a_valid, a_cmd,
    input  b_valid, b_cmd,
    output a_ready, b_ready,
    output rsp_valid, rsp_err,
    output rsp_a_used, rsp_a_ack,
    output rsp_b_used, rsp_b_ack
  );
endinterface

// File: rtl/ats21_cmd_conflict.sv
// Combinational grant logic for the two ATS21 clients;
// on a resource clash only the round-robin favourite wins.
module ats21_cmd_conflict
  import ats21_pkg::*;
(
  input  instr_t a_cmd,
  input  instr_t b_cmd,
  input  logic   a_valid,
  input  logic   b_valid,
  input  logic   rr_ptr,
  output logic   grant_a,
  output logic   grant_b
);

  logic clk_pair;
  logic alm_pair;
  logic mode_pair;
  logic conflict;
  logic unused_payload;

  assign unused_payload = ^{a_cmd.payload,
                            b_cmd.payload};

  assign clk_pair = is_clock_op(a_cmd.op) &&
                    is_clock_op(b_cmd.op);
  assign alm_pair = is_alarm_op(a_cmd.op) &&
                    is_alarm_op(b_cmd.op);
  assign mode_pair = (a_cmd.op == OP_MODE) &&
                     (b_cmd.op == OP_MODE);

  // Clock ops share a clock pair, so bit 0 of target is ignored
  always_comb begin
    conflict = 1'b0;
    unique case (1'b1)
      clk_pair:
        conflict = a_cmd.target[4:1] ==
                   b_cmd.target[4:1];
      alm_pair:
        conflict = a_cmd.target ==
                   b_cmd.target;
      mode_pair:
        conflict = 1'b1;
      default:
        conflict = 1'b0;
    endcase
  end

  assign grant_a = a_valid &&
                   (!b_valid || !conflict || !rr_ptr);
  assign grant_b = b_valid &&
                   (!a_valid || !conflict || rr_ptr);

endmodule

// File: rtl/ats21_cmd_sequencer.sv
// ATS21 command sequencer: arbitrates clients A/B and runs
// the req / ready / hi beat / lo beat / status transaction.
module ats21_cmd_sequencer
  import ats21_pkg::*;
#(
  parameter int         RDY_TIMEOUT = 16,
  parameter int         STAT_LAT    = 2,
  parameter logic [2:0] NOP_OP      = 3'b000
) (
  input  logic                   clk,
  input  logic                   reset,
  ats21_cmd_sequencer_if.slave   host,
  output logic                   ats_req,
  output logic [15:0]            ats_ctrlA,
  output logic [15:0]            ats_ctrlB,
  input  logic                   ats_ready,
  input  logic [1:0]             ats_statA,
  input  logic [1:0]             ats_statB
);

  localparam int CNT_MAX =
    (RDY_TIMEOUT > STAT_LAT) ? RDY_TIMEOUT : STAT_LAT;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST =
    CNT_W'(STAT_LAT - 1);
  localparam logic [31:0] NOP_WORD = {NOP_OP, 29'b0};

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             rr_ptr;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic             used_a;
  logic             used_b;
  logic             err;
  logic             grant_a;
  logic             grant_b;
  logic             any_valid;
  logic             unused_stat;
  instr_t           ia;
  instr_t           ib;

  assign unused_stat = ^{ats_statA[1], ats_statB[1]};
  assign any_valid = host.a_valid || host.b_valid;
  assign ia = instr_t'(host.a_cmd);
  assign ib = instr_t'(host.b_cmd);

  ats21_cmd_conflict u_conflict (
    .a_cmd   (ia),
    .b_cmd   (ib),
    .a_valid (host.a_valid),
    .b_valid (host.b_valid),
    .rr_ptr  (rr_ptr),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (any_valid) state_nx = S_REQ;
      S_REQ:
        state_nx = S_WAIT_RDY;
      S_WAIT_RDY:
        if (ats_ready)           state_nx = S_BEAT_HI;
        else if (cnt == TO_LAST) state_nx = S_RESP;
      S_BEAT_HI:
        state_nx = S_BEAT_LO;
      S_BEAT_LO:
        state_nx = S_WAIT_STAT;
      S_WAIT_STAT:
        if (cnt == ST_LAST) state_nx = S_RESP;
      S_RESP:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      rr_ptr <= 1'b0;
      cmd_a  <= '0;
      cmd_b  <= '0;
      used_a <= 1'b0;
      used_b <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:
          if (any_valid) begin
            cmd_a  <= grant_a ? host.a_cmd : NOP_WORD;
            cmd_b  <= grant_b ? host.b_cmd : NOP_WORD;
            used_a <= grant_a;
            used_b <= grant_b;
            err    <= 1'b0;
            if (host.a_valid && host.b_valid)
              rr_ptr <= ~rr_ptr;
          end
        S_REQ:
          cnt <= '0;
        S_WAIT_RDY:
          if (!ats_ready) begin
            if (cnt == TO_LAST) err <= 1'b1;
            else                cnt <= cnt + 1'b1;
          end
        S_BEAT_LO:
          cnt <= '0;
        S_WAIT_STAT:
          if (cnt != ST_LAST) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs are held low while reset is asserted
  always_comb begin
    host.a_ready    = 1'b0;
    host.b_ready    = 1'b0;
    host.rsp_valid  = 1'b0;
    host.rsp_a_used = 1'b0;
    host.rsp_a_ack  = 1'b0;
    host.rsp_b_used = 1'b0;
    host.rsp_b_ack  = 1'b0;
    host.rsp_err    = 1'b0;
    ats_req         = 1'b0;
    ats_ctrlA       = '0;
    ats_ctrlB       = '0;
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          host.a_ready = grant_a;
          host.b_ready = grant_b;
        end
        S_REQ:
          ats_req = 1'b1;
        S_BEAT_HI: begin
          ats_ctrlA = cmd_a[31:16];
          ats_ctrlB = cmd_b[31:16];
        end
        S_BEAT_LO: begin
          ats_ctrlA = cmd_a[15:0];
          ats_ctrlB = cmd_b[15:0];
        end
        S_RESP: begin
          host.rsp_valid  = 1'b1;
          host.rsp_a_used = used_a;
          host.rsp_b_used = used_b;
          host.rsp_a_ack  = used_a && ats_statA[0] && !err;
          host.rsp_b_ack  = used_b && ats_statB[0] && !err;
          host.rsp_err    = err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// Self-checking bench for ats21_cmd_sequencer: directed
// scenarios then randomized transactions against a model.
module tb_ats21_cmd_sequencer;

  localparam int RDY_TIMEOUT = 16;
  localparam int STAT_LAT    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ats_req;
  logic [15:0] ats_ctrlA;
  logic [15:0] ats_ctrlB;
  logic        ats_ready;
  logic [1:0]  ats_statA;
  logic [1:0]  ats_statB;

  ats21_cmd_sequencer_if host ();

  ats21_cmd_sequencer #(
    .RDY_TIMEOUT (RDY_TIMEOUT),
    .STAT_LAT    (STAT_LAT),
    .NOP_OP      (3'b000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host),
    .ats_req   (ats_req),
    .ats_ctrlA (ats_ctrlA),
    .ats_ctrlB (ats_ctrlB),
    .ats_ready (ats_ready),
    .ats_statA (ats_statA),
    .ats_statB (ats_statB)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit rr_model = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic rand_stat();
    ats_statA = 2'($urandom);
    ats_statB = 2'($urandom);
  endtask

  function automatic bit ref_conflict(
    input logic [31:0] a, input logic [31:0] b);
    int oa = int'(a[31:29]);
    int ob = int'(b[31:29]);
    bit ca = (oa == 1) || (oa == 2);
    bit cb = (ob == 1) || (ob == 2);
    bit la = (oa >= 5);
    bit lb = (ob >= 5);
    if (ca && cb) return a[28:25] == b[28:25];
    if (la && lb) return a[28:24] == b[28:24];
    return (oa == 3) && (ob == 3);
  endfunction

  task automatic txn(input bit av, input logic [31:0] ac,
                     input bit bv, input logic [31:0] bc,
                     input int d,
                     input logic [1:0] sa,
                     input logic [1:0] sb,
                     input bit rst_hi,
                     output bit ga, output bit gb);
    bit cf;
    bit to;
    logic [15:0] ea;
    logic [15:0] eb;
    cf = av && bv && ref_conflict(ac, bc);
    ga = av && (!cf || !rr_model);
    gb = bv && (!cf || rr_model);
    if (av && bv) rr_model = !rr_model;

    @(negedge clk);
    reset = 1'b0;
    host.a_valid = av; host.a_cmd = ac;
    host.b_valid = bv; host.b_cmd = bc;
    ats_ready = 1'b0; rand_stat();
    #2;
    chk("idle_a_ready", 32'(host.a_ready), 32'(ga));
    chk("idle_b_ready", 32'(host.b_ready), 32'(gb));
    chk("idle_req", 32'(ats_req), 0);
    chk("idle_ctrlA", 32'(ats_ctrlA), 0);
    chk("idle_ctrlB", 32'(ats_ctrlB), 0);
    chk("idle_rsp", 32'(host.rsp_valid), 0);

    @(negedge clk);
    host.a_valid = av && !ga;
    host.b_valid = bv && !gb;
    rand_stat();
    #2;
    chk("req_pulse", 32'(ats_req), 1);
    chk("req_a_ready", 32'(host.a_ready), 0);
    chk("req_b_ready", 32'(host.b_ready), 0);

    to = 1'b1;
    for (int i = 0; i < RDY_TIMEOUT; i++) begin
      @(negedge clk);
      ats_ready = (i == d); rand_stat();
      #2;
      chk("wait_req", 32'(ats_req), 0);
      chk("wait_rsp", 32'(host.rsp_valid), 0);
      if (i == d) begin
        to = 1'b0;
        break;
      end
    end

    if (!to) begin
      @(negedge clk);
      ats_ready = 1'b0; rand_stat();
      if (rst_hi) reset = 1'b1;
      #2;
      if (rst_hi) begin
        chk("rst_ctrlA", 32'(ats_ctrlA), 0);
        chk("rst_ctrlB", 32'(ats_ctrlB), 0);
        rr_model = 1'b0;
        return;
      end
      ea = ga ? ac[31:16] : 16'h0000;
      eb = gb ? bc[31:16] : 16'h0000;
      chk("hi_ctrlA", 32'(ats_ctrlA), 32'(ea));
      chk("hi_ctrlB", 32'(ats_ctrlB), 32'(eb));

      @(negedge clk);
      rand_stat();
      #2;
      ea = ga ? ac[15:0] : 16'h0000;
      eb = gb ? bc[15:0] : 16'h0000;
      chk("lo_ctrlA", 32'(ats_ctrlA), 32'(ea));
      chk("lo_ctrlB", 32'(ats_ctrlB), 32'(eb));

      for (int k = 0; k < STAT_LAT; k++) begin
        @(negedge clk);
        rand_stat();
        #2;
        chk("stat_ctrlA", 32'(ats_ctrlA), 0);
        chk("stat_rsp", 32'(host.rsp_valid), 0);
      end
    end

    @(negedge clk);
    ats_ready = 1'b0;
    ats_statA = sa; ats_statB = sb;
    #2;
    chk("rsp_valid", 32'(host.rsp_valid), 1);
    chk("rsp_a_used", 32'(host.rsp_a_used), 32'(ga));
    chk("rsp_b_used", 32'(host.rsp_b_used), 32'(gb));
    chk("rsp_a_ack", 32'(host.rsp_a_ack),
        32'(ga && sa[0] && !to));
    chk("rsp_b_ack", 32'(host.rsp_b_ack),
        32'(gb && sb[0] && !to));
    chk("rsp_err", 32'(host.rsp_err), 32'(to));
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [2:0] ops [7] = '{3'd0, 3'd1, 3'd2, 3'd3,
                           3'd5, 3'd6, 3'd7};
    logic [2:0]  op  = ops[$urandom_range(0, 6)];
    logic [4:0]  tgt = 5'($urandom_range(0, 3));
    logic [23:0] pl  = 24'($urandom);
    return {op, tgt, pl};
  endfunction

  initial begin
    bit ga, gb;
    bit pa, pb;
    bit av, bv;
    logic [31:0] ca, cb;
    int d;

    reset = 1'b1;
    ats_ready = 1'b0;
    ats_statA = 2'b01; ats_statB = 2'b01;
    host.a_valid = 1'b1; host.a_cmd = 32'h2000_0064;
    host.b_valid = 1'b0; host.b_cmd = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_a_ready", 32'(host.a_ready), 0);
    chk("rst_req", 32'(ats_req), 0);
    chk("rst_rsp", 32'(host.rsp_valid), 0);
    chk("rst_ctrl", 32'(ats_ctrlA), 0);

    txn(1, 32'h2000_0064, 0, 0, 1, 2'b01, 2'b00,
        0, ga, gb);

    txn(1, 32'hA300_0010, 1, 32'hA300_0020, 0,
        2'b01, 2'b01, 0, ga, gb);
    txn(1, 32'hA300_0030, 1, 32'hA300_0020, 2,
        2'b01, 2'b01, 0, ga, gb);
    txn(1, 32'hA300_0030, 0, 0, 0,
        2'b01, 2'b01, 0, ga, gb);

    txn(1, 32'h2000_0001, 1, 32'h2200_0002, 0,
        2'b01, 2'b00, 0, ga, gb);

    txn(1, 32'h6000_0005, 0, 0, 99,
        2'b01, 2'b01, 0, ga, gb);

    txn(1, 32'h4100_0abc, 0, 0, 0,
        2'b01, 2'b01, 1, ga, gb);
    txn(1, 32'h4100_0abc, 0, 0, 0,
        2'b01, 2'b01, 0, ga, gb);

    txn(1, 32'h2400_1111, 0, 0, 0,
        2'b01, 2'b01, 0, ga, gb);
    txn(1, 32'h2400_2222, 0, 0, 3,
        2'b00, 2'b01, 0, ga, gb);

    pa = 0; pb = 0; ca = 0; cb = 0;
    for (int n = 0; n < 40; n++) begin
      av = pa; bv = pb;
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        av = 1; ca = rand_cmd();
      end
      if (!pb && ($urandom_range(0, 3) != 0)) begin
        bv = 1; cb = rand_cmd();
      end
      if (!av && !bv) begin
        av = 1; ca = rand_cmd();
      end
      d = ($urandom_range(0, 7) == 0) ? 40
                                      : $urandom_range(0, 3);
      txn(av, ca, bv, cb, d, 2'($urandom), 2'($urandom),
          0, ga, gb);
      pa = av && !ga;
      pb = bv && !gb;
    end

    @(negedge clk);
    host.a_valid = 1'b0;
    host.b_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
